alkaluenc_seq: RTL and testbench
================================

ALKALUENC_SEQ -- requirements
Module: alkaluenc_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_l  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 req_valid_h  input  1  operation request valid.
REQ-004 req_ready_h  output  1  block accepts request this cycle.
REQ-005 req_op_h  input  3  op class: 0 PASS, 1 ADD, 2 SUB, 3 RSUB, 4 BCD, 5 SHL, 6 SHR, 7 reserved.
REQ-006 req_cnt_h  input  4  shift repeat count; shift steps = req_cnt_h+1; ignored for non-shift ops.
REQ-007 req_lit_h  input  1  op uses a long literal; precede op with one literal cycle.
REQ-008 abort_h  input  1  abandon current op.
REQ-009 alu_h  output  4  ALU micro-op field driven to the ALK.
REQ-010 long_lit_l  output  1  long-literal gate, active low.
REQ-011 busy_h  output  1  high whenever state is not IDLE.
REQ-012 done_h  output  1  one-cycle pulse on final issue cycle of an op.

Function
REQ-013 Encoding SHALL be: PASS 1000, ADD 0100, SUB 0000, RSUB 1100, BCD 0101, SHL 0111, SHR 0110.
REQ-014 States SHALL be IDLE, LIT, ISSUE, SHIFT.
REQ-015 req_ready_h SHALL equal (state==IDLE) & ~abort_h; a request is accepted when req_valid_h & req_ready_h.
REQ-016 On accept: op, count, lit SHALL be captured into registers; next state LIT if lit else (SHIFT if op is SHL/SHR else ISSUE).
REQ-017 LIT: long_lit_l=0, alu_h=captured op code, one cycle; next SHIFT for shift ops, else ISSUE.
REQ-018 ISSUE: long_lit_l=1, alu_h=op code, done_h=1, one cycle; next IDLE.
REQ-019 SHIFT: long_lit_l=1, alu_h=shift code; down-counter loaded with captured count; each cycle decrements; done_h=1 and next IDLE on cycle where counter==0.
REQ-020 Total issue cycles after accept SHALL be: non-shift 1 (+1 if lit); shift cnt+1 (+1 if lit); cnt=15 gives 16 shift cycles with no wrap.
REQ-021 IDLE outputs: alu_h=1000, long_lit_l=1, done_h=0, busy_h=0.
REQ-022 Outputs alu_h, long_lit_l, done_h SHALL be registered (no combinational path from request inputs).
REQ-023 Reserved op 7 SHALL be accepted and executed as PASS.
REQ-024 abort_h in any non-IDLE state: next cycle state IDLE, outputs IDLE values, no done_h for the aborted op.
REQ-025 abort_h and req_valid_h together in IDLE: request not accepted, state stays IDLE.
REQ-026 Back-to-back: next request accepted no earlier than the cycle after done_h (ready only in IDLE).
REQ-027 Request inputs SHALL be ignored while busy_h=1.

Reset
REQ-028 reset_l=0 at a clock edge SHALL force state IDLE, alu_h=1000, long_lit_l=1, done_h=0, busy_h=0, counter=0, captured regs=0, regardless of state or abort_h.
REQ-029 Reset mid-op SHALL discard the op without a done_h pulse.

Structure
REQ-030 ALU op codes (4-bit values of REQ-013), op-class enumeration and state encoding SHALL live in the shared ucode definitions package/header.
REQ-031 The op-class-to-alu_h encoder SHALL be one combinational sub-module, alkaluenc_map; all sequencing stays in alkaluenc_seq.

Verification
REQ-032 Reset: hold reset_l=0 two cycles mid-SHIFT -> alu_h=1000, long_lit_l=1, busy_h=0, no done_h.
REQ-033 SUB, no lit: accept at T -> T+1 alu_h=0000, done_h=1; T+2 alu_h=1000, req_ready_h=1.
REQ-034 RSUB with lit: accept at T -> T+1 long_lit_l=0 alu_h=1100; T+2 long_lit_l=1 alu_h=1100 done_h=1.
REQ-035 SHL cnt=3: accept at T -> T+1..T+4 alu_h=0111, done_h only at T+4; cnt=15 -> exactly 16 cycles.
REQ-036 SHR cnt=5, abort_h at 3rd shift cycle -> next cycle alu_h=1000, busy_h=0, no done_h; abort_h with req_valid_h in IDLE -> req_ready_h=0, no accept.
REQ-037 BCD then immediate ADD request held valid -> alu_h 0101 (done_h), 1000 (ready), then 0100 (done_h).

Source files
------------

// File: rtl/alkaluenc_pkg.sv
// rtl/alkaluenc_pkg.sv - shared ucode definitions for the ALK ALU-field encoder
package alkaluenc_pkg;

  // Request op classes as presented on req_op_h
  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_RSUB = 3'd3,
    OP_BCD  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LIT   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  // ALU micro-op field values driven to the ALK
  localparam logic [3:0] ALU_PASS = 4'b1000;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0000;
  localparam logic [3:0] ALU_RSUB = 4'b1100;
  localparam logic [3:0] ALU_BCD  = 4'b0101;
  localparam logic [3:0] ALU_SHL  = 4'b0111;
  localparam logic [3:0] ALU_SHR  = 4'b0110;

  localparam int CNT_W = 4;

  // Shift ops repeat in the SHIFT state; everything else issues once
  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alkaluenc_map.sv
// rtl/alkaluenc_map.sv - combinational op-class to ALU micro-op field encoder
module alkaluenc_map
  import alkaluenc_pkg::*;
(
  input  op_e        i_op,
  output logic [3:0] o_alu
);

  // Pure lookup; the reserved class falls back to PASS
  always_comb begin
    o_alu = ALU_PASS;
    case (i_op)
      OP_PASS: o_alu = ALU_PASS;
      OP_ADD:  o_alu = ALU_ADD;
      OP_SUB:  o_alu = ALU_SUB;
      OP_RSUB: o_alu = ALU_RSUB;
      OP_BCD:  o_alu = ALU_BCD;
      OP_SHL:  o_alu = ALU_SHL;
      OP_SHR:  o_alu = ALU_SHR;
      OP_RSVD: o_alu = ALU_PASS;
      default: o_alu = ALU_PASS;
    endcase
  end

endmodule

// File: rtl/alkaluenc_seq.sv
// rtl/alkaluenc_seq.sv - ALK ALU-field sequencer: literal, issue and shift-repeat phases
module alkaluenc_seq
  import alkaluenc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_l,
  input  logic       req_valid_h,
  output logic       req_ready_h,
  input  logic [2:0] req_op_h,
  input  logic [3:0] req_cnt_h,
  input  logic       req_lit_h,
  input  logic       abort_h,
  output logic [3:0] alu_h,
  output logic       long_lit_l,
  output logic       busy_h,
  output logic       done_h
);

  state_e           r_state;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lit;
  logic [CNT_W-1:0] r_ctr;
  logic [3:0]       r_alu;
  logic             r_long_lit_l;
  logic             r_done;

  op_e              w_req_op;
  logic [3:0]       w_req_alu;
  logic             w_accept;

  assign w_req_op = op_e'(req_op_h);

  alkaluenc_map u_map (
    .i_op  (w_req_op),
    .o_alu (w_req_alu)
  );

  // Abort in IDLE blocks acceptance so the request cannot slip in alongside it
  assign req_ready_h = (r_state == ST_IDLE) && !abort_h;
  assign w_accept    = req_valid_h && req_ready_h;

  assign alu_h      = r_alu;
  assign long_lit_l = r_long_lit_l;
  assign done_h     = r_done;
  assign busy_h     = (r_state != ST_IDLE);

  // Sequencer: outputs are registered together with the state they belong to,
  // so every output value is decided one edge before it is shown
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_PASS;
      r_cnt        <= '0;
      r_lit        <= 1'b0;
      r_ctr        <= '0;
      r_alu        <= ALU_PASS;
      r_long_lit_l <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_alu        <= ALU_PASS;
          r_long_lit_l <= 1'b1;
          r_done       <= 1'b0;
          if (w_accept) begin
            r_op  <= w_req_op;
            r_cnt <= req_cnt_h;
            r_lit <= req_lit_h;
            r_alu <= w_req_alu;
            if (req_lit_h) begin
              // Literal cycle first; the op code is already on the field
              r_state      <= ST_LIT;
              r_long_lit_l <= 1'b0;
            end else if (is_shift(w_req_op)) begin
              // A zero count is a single shift step that is also the last
              r_state <= ST_SHIFT;
              r_ctr   <= req_cnt_h;
              r_done  <= (req_cnt_h == '0);
            end else begin
              r_state <= ST_ISSUE;
              r_done  <= 1'b1;
            end
          end
        end

        ST_LIT: begin
          // A LIT phase without a captured literal is treated as stray and dropped
          if (abort_h || !r_lit) begin
            r_state      <= ST_IDLE;
            r_alu        <= ALU_PASS;
            r_long_lit_l <= 1'b1;
            r_done       <= 1'b0;
          end else if (is_shift(r_op)) begin
            r_state      <= ST_SHIFT;
            r_ctr        <= r_cnt;
            r_long_lit_l <= 1'b1;
            r_done       <= (r_cnt == '0);
          end else begin
            r_state      <= ST_ISSUE;
            r_long_lit_l <= 1'b1;
            r_done       <= 1'b1;
          end
        end

        ST_ISSUE: begin
          r_state      <= ST_IDLE;
          r_alu        <= ALU_PASS;
          r_long_lit_l <= 1'b1;
          r_done       <= 1'b0;
        end

        ST_SHIFT: begin
          if (abort_h || (r_ctr == '0)) begin
            r_state      <= ST_IDLE;
            r_alu        <= ALU_PASS;
            r_long_lit_l <= 1'b1;
            r_done       <= 1'b0;
          end else begin
            // The step that brings the counter to zero is the final one
            r_ctr  <= r_ctr - 1'b1;
            r_done <= (r_ctr == 4'd1);
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_alu        <= ALU_PASS;
          r_long_lit_l <= 1'b1;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alkaluenc_seq.sv
// tb/tb_alkaluenc_seq.sv - scoreboard bench for alkaluenc_seq
module tb_alkaluenc_seq;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       req_valid_h;
  logic       req_ready_h;
  logic [2:0] req_op_h;
  logic [3:0] req_cnt_h;
  logic       req_lit_h;
  logic       abort_h;
  logic [3:0] alu_h;
  logic       long_lit_l;
  logic       busy_h;
  logic       done_h;

  alkaluenc_seq dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .req_valid_h (req_valid_h),
    .req_ready_h (req_ready_h),
    .req_op_h    (req_op_h),
    .req_cnt_h   (req_cnt_h),
    .req_lit_h   (req_lit_h),
    .abort_h     (abort_h),
    .alu_h       (alu_h),
    .long_lit_l  (long_lit_l),
    .busy_h      (busy_h),
    .done_h      (done_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] alu;
    logic       ll;
    logic       dn;
    logic       bz;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int off, input logic [3:0] alu, input logic ll,
                      input logic dn, input logic bz, input logic rdy, input string name);
    exp_t e;
    e.cyc = cyc + off; e.alu = alu; e.ll = ll; e.dn = dn; e.bz = bz; e.rdy = rdy; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [3:0] cnt, input logic lit);
    req_valid_h = 1'b1; req_op_h = op; req_cnt_h = cnt; req_lit_h = lit;
  endtask

  // Monitor: at each falling edge, compare every expectation due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (alu_h !== e.alu || long_lit_l !== e.ll || done_h !== e.dn ||
                   busy_h !== e.bz || req_ready_h !== e.rdy) begin
        n_bad++;
        $display("FAIL %s @%0d: got alu=%b ll=%b done=%b busy=%b rdy=%b, want alu=%b ll=%b done=%b busy=%b rdy=%b",
                 e.name, cyc, alu_h, long_lit_l, done_h, busy_h, req_ready_h,
                 e.alu, e.ll, e.dn, e.bz, e.rdy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0; req_valid_h = 1'b0; req_op_h = 3'd0; req_cnt_h = 4'd0;
    req_lit_h = 1'b0; abort_h = 1'b0;
    tick(2);
    push(0, 4'b1000, 1, 0, 0, 1, "reset_state");
    tick(1);
    reset_l = 1'b1;
    tick(1);

    // SUB, no literal
    push(1, 4'b0000, 1, 1, 1, 0, "sub_issue");
    push(2, 4'b1000, 1, 0, 0, 1, "sub_idle");
    req(3'd2, 4'd0, 1'b0); tick(1); req_valid_h = 1'b0; tick(2);

    // RSUB with literal
    push(1, 4'b1100, 0, 0, 1, 0, "rsub_lit");
    push(2, 4'b1100, 1, 1, 1, 0, "rsub_issue");
    push(3, 4'b1000, 1, 0, 0, 1, "rsub_idle");
    req(3'd3, 4'd0, 1'b1); tick(1); req_valid_h = 1'b0; tick(3);

    // SHL cnt=3: four shift cycles, done on the last
    for (int i = 1; i <= 3; i++) push(i, 4'b0111, 1, 0, 1, 0, "shl3_step");
    push(4, 4'b0111, 1, 1, 1, 0, "shl3_last");
    push(5, 4'b1000, 1, 0, 0, 1, "shl3_idle");
    req(3'd5, 4'd3, 1'b0); tick(1); req_valid_h = 1'b0; tick(5);

    // SHL cnt=15: sixteen shift cycles, no wrap
    for (int i = 1; i <= 15; i++) push(i, 4'b0111, 1, 0, 1, 0, "shl15_step");
    push(16, 4'b0111, 1, 1, 1, 0, "shl15_last");
    push(17, 4'b1000, 1, 0, 0, 1, "shl15_idle");
    req(3'd5, 4'd15, 1'b0); tick(1); req_valid_h = 1'b0; tick(17);

    // SHR cnt=0 with literal: one literal cycle then a single shift
    push(1, 4'b0110, 0, 0, 1, 0, "shr0_lit");
    push(2, 4'b0110, 1, 1, 1, 0, "shr0_last");
    push(3, 4'b1000, 1, 0, 0, 1, "shr0_idle");
    req(3'd6, 4'd0, 1'b1); tick(1); req_valid_h = 1'b0; tick(3);

    // SHR cnt=5, abort on the third shift cycle
    for (int i = 1; i <= 3; i++) push(i, 4'b0110, 1, 0, 1, 0, "shr5_step");
    push(4, 4'b1000, 1, 0, 0, 1, "shr5_aborted");
    push(5, 4'b1000, 1, 0, 0, 1, "shr5_no_done");
    req(3'd6, 4'd5, 1'b0); tick(1); req_valid_h = 1'b0; tick(2);
    abort_h = 1'b1; tick(1); abort_h = 1'b0; tick(2);

    // Abort together with a request in IDLE: not accepted
    push(0, 4'b1000, 1, 0, 0, 0, "abort_idle_rdy");
    push(1, 4'b1000, 1, 0, 0, 1, "abort_idle_noacc");
    push(2, 4'b1000, 1, 0, 0, 1, "abort_idle_stay");
    req(3'd1, 4'd0, 1'b0); abort_h = 1'b1; tick(1);
    req_valid_h = 1'b0; abort_h = 1'b0; tick(2);

    // Reserved op runs as PASS
    push(1, 4'b1000, 1, 1, 1, 0, "rsvd_issue");
    push(2, 4'b1000, 1, 0, 0, 1, "rsvd_idle");
    req(3'd7, 4'd9, 1'b0); tick(1); req_valid_h = 1'b0; tick(2);

    // PASS with literal
    push(1, 4'b1000, 0, 0, 1, 0, "pass_lit");
    push(2, 4'b1000, 1, 1, 1, 0, "pass_issue");
    req(3'd0, 4'd0, 1'b1); tick(1); req_valid_h = 1'b0; tick(3);

    // BCD then ADD held valid; the held request is ignored while busy
    push(1, 4'b0101, 1, 1, 1, 0, "bcd_issue");
    push(2, 4'b1000, 1, 0, 0, 1, "b2b_idle");
    push(3, 4'b0100, 1, 1, 1, 0, "add_issue");
    push(4, 4'b1000, 1, 0, 0, 1, "add_idle");
    req(3'd4, 4'd0, 1'b0); tick(1);
    req(3'd1, 4'd0, 1'b0); tick(2);
    req_valid_h = 1'b0; tick(2);

    // Reset held two cycles mid-SHIFT discards the op
    push(1, 4'b0111, 1, 0, 1, 0, "rst_shift1");
    push(2, 4'b0111, 1, 0, 1, 0, "rst_shift2");
    for (int i = 3; i <= 6; i++) push(i, 4'b1000, 1, 0, 0, 1, "rst_discard");
    req(3'd5, 4'd10, 1'b0); tick(1); req_valid_h = 1'b0; tick(1);
    reset_l = 1'b0; tick(2); reset_l = 1'b1; tick(3);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations never reached, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
